// File: rtl/bitstream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_decoder
// Description : Serial packet receiver; checks the PID, assembles the fields
//               it implies and holds the result under a ready/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bitstream_decoder (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        inb,
    input  logic        sending,
    input  logic        pause,
    input  logic        pkt_ack,
    output logic        pktready,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [63:0] data,
    output logic        pid_err,
    output logic        trunc_err,
    output logic        overrun
);

    localparam logic [3:0] c_PID_OUT   = 4'b0001;
    localparam logic [3:0] c_PID_IN    = 4'b1001;
    localparam logic [3:0] c_PID_DATA0 = 4'b0011;
    localparam logic [3:0] c_PID_ACK   = 4'b0010;
    localparam logic [3:0] c_PID_NAK   = 4'b1010;

    // Packet completion is resolved on the edge that accepts the final bit,
    // so it has no state of its own.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RX_PID   = 3'd1,
        S_RX_ADDR  = 3'd2,
        S_RX_ENDP  = 3'd3,
        S_RX_DATA  = 3'd4,
        S_WAIT_END = 3'd5,
        S_DISCARD  = 3'd6
    } state_t;

    state_t      r_state, w_state_next;
    logic [6:0]  r_cnt, w_cnt_next;
    logic [63:0] r_sr, w_sr_next, w_sr_bit;
    logic [3:0]  r_rx_pid, w_rx_pid_next, w_pkt_pid;
    logic [5:0]  w_idx;
    logic        w_accept, w_complete, w_pid_err, w_trunc, w_is_token;

    assign w_accept   = sending && !pause;
    assign w_pkt_pid  = (r_state == S_RX_PID) ? w_sr_bit[3:0] : r_rx_pid;
    assign w_is_token = (w_pkt_pid == c_PID_OUT) || (w_pkt_pid == c_PID_IN);

    // ENDP lands just above ADDR so both survive until completion.
    always_comb begin
        w_idx = (r_state == S_RX_ENDP) ? (6'd7 + r_cnt[5:0]) : r_cnt[5:0];
        w_sr_bit        = r_sr;
        w_sr_bit[w_idx] = inb;
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_sr_next     = r_sr;
        w_rx_pid_next = r_rx_pid;
        w_complete    = 1'b0;
        w_pid_err     = 1'b0;
        w_trunc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_sr_next    = w_sr_bit;
                    w_cnt_next   = 7'd1;
                    w_state_next = S_RX_PID;
                end
            end
            S_RX_PID, S_RX_ADDR, S_RX_ENDP, S_RX_DATA: begin
                if (!sending) begin
                    w_trunc      = 1'b1;
                    w_cnt_next   = 7'd0;
                    w_sr_next    = 64'd0;
                    w_state_next = S_IDLE;
                end else if (w_accept) begin
                    w_sr_next  = w_sr_bit;
                    w_cnt_next = r_cnt + 7'd1;
                    if (r_state == S_RX_PID && r_cnt == 7'd7) begin
                        w_cnt_next    = 7'd0;
                        w_rx_pid_next = w_sr_bit[3:0];
                        if (w_sr_bit[7:4] != ~w_sr_bit[3:0]) begin
                            w_pid_err    = 1'b1;
                            w_state_next = S_DISCARD;
                        end else begin
                            case (w_sr_bit[3:0])
                                c_PID_ACK, c_PID_NAK: begin
                                    w_complete   = 1'b1;
                                    w_state_next = S_WAIT_END;
                                end
                                c_PID_OUT, c_PID_IN: w_state_next = S_RX_ADDR;
                                c_PID_DATA0:         w_state_next = S_RX_DATA;
                                default: begin
                                    w_pid_err    = 1'b1;
                                    w_state_next = S_DISCARD;
                                end
                            endcase
                        end
                    end else if (r_state == S_RX_ADDR && r_cnt == 7'd6) begin
                        w_cnt_next   = 7'd0;
                        w_state_next = S_RX_ENDP;
                    end else if ((r_state == S_RX_ENDP && r_cnt == 7'd3) ||
                                 (r_state == S_RX_DATA && r_cnt == 7'd63)) begin
                        w_cnt_next   = 7'd0;
                        w_complete   = 1'b1;
                        w_state_next = S_WAIT_END;
                    end
                end
            end
            S_WAIT_END, S_DISCARD: begin
                w_cnt_next = 7'd0;
                if (!sending) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state   <= S_IDLE;
            r_cnt     <= 7'd0;
            r_sr      <= 64'd0;
            r_rx_pid  <= 4'd0;
            pktready  <= 1'b0;
            pid       <= 4'd0;
            addr      <= 7'd0;
            endp      <= 4'd0;
            data      <= 64'd0;
            pid_err   <= 1'b0;
            trunc_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_sr      <= w_sr_next;
            r_rx_pid  <= w_rx_pid_next;
            pid_err   <= w_pid_err;
            trunc_err <= w_trunc;
            overrun   <= w_complete && pktready;
            // A simultaneous ack and completion still counts as overrun.
            if (w_complete && !pktready) begin
                pktready <= 1'b1;
                pid      <= w_pkt_pid;
                addr     <= w_is_token ? w_sr_bit[6:0]  : 7'd0;
                endp     <= w_is_token ? w_sr_bit[10:7] : 4'd0;
                data     <= (w_pkt_pid == c_PID_DATA0) ? w_sr_bit : 64'd0;
            end else if (pkt_ack && pktready) begin
                pktready <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitstream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitstream_decoder
// Description : Directed self-checking bench for bitstream_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitstream_decoder;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        inb = 1'b0;
    logic        sending = 1'b0;
    logic        pause = 1'b0;
    logic        pkt_ack = 1'b0;
    logic        pktready;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        pid_err;
    logic        trunc_err;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;
    int n_pid_err = 0;
    int n_trunc = 0;
    int n_overrun = 0;

    bitstream_decoder dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .inb       (inb),
        .sending   (sending),
        .pause     (pause),
        .pkt_ack   (pkt_ack),
        .pktready  (pktready),
        .pid       (pid),
        .addr      (addr),
        .endp      (endp),
        .data      (data),
        .pid_err   (pid_err),
        .trunc_err (trunc_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Inputs are applied at a falling edge; on return the outputs show the
    // result of the rising edge that sampled them.
    task automatic drive(input logic s, input logic p, input logic b, input logic a);
        sending = s;
        pause   = p;
        inb     = b;
        pkt_ack = a;
        @(negedge clk);
        n_pid_err += int'(pid_err);
        n_trunc   += int'(trunc_err);
        n_overrun += int'(overrun);
    endtask

    task automatic send_pkt(input logic [87:0] bits, input int len, input logic ack_last);
        for (int i = 0; i < len; i++) begin
            drive(1'b1, 1'b0, bits[i], (i == len - 1) ? ack_last : 1'b0);
        end
    endtask

    function automatic logic [87:0] mk_tok(input logic [3:0] p, input logic [6:0] a,
                                           input logic [3:0] e);
        logic [87:0] v;
        v        = '0;
        v[7:0]   = {~p, p};
        v[14:8]  = a;
        v[18:15] = e;
        return v;
    endfunction

    function automatic logic [87:0] mk_data(input logic [63:0] d);
        logic [87:0] v;
        v       = '0;
        v[7:0]  = 8'h3C ^ 8'hFF;
        v[71:8] = d;
        return v;
    endfunction

    function automatic logic [87:0] mk_hs(input logic [3:0] p);
        logic [87:0] v;
        v      = '0;
        v[7:0] = {~p, p};
        return v;
    endfunction

    task automatic test_reset;
        #1;
        vectors++;
        if ({pktready, pid, addr, endp, data, pid_err, trunc_err, overrun} !== 83'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                     {pktready, pid, addr, endp, data, pid_err, trunc_err, overrun});
        end
        @(negedge clk);
        rst_L = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({pktready, pid_err, trunc_err, overrun} !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 0000",
                     {pktready, pid_err, trunc_err, overrun});
        end
    endtask

    task automatic test_out;
        logic [87:0] v;
        v = mk_tok(4'h1, 7'h6D, 4'hD);
        send_pkt(v, 18, 1'b0);
        vectors++;
        if (pktready !== 1'b0) begin
            miscompares++;
            $display("FAIL out_early_ready: got %b want 0", pktready);
        end
        drive(1'b1, 1'b0, v[18], 1'b0);
        vectors++;
        if ({pktready, pid, addr, endp, data} !== {1'b1, 4'h1, 7'h6D, 4'hD, 64'h0}) begin
            miscompares++;
            $display("FAIL out_fields: got rdy=%b pid=%h addr=%h endp=%h data=%h want 1 1 6d d 0",
                     pktready, pid, addr, endp, data);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if ({pktready, pid, addr} !== {1'b0, 4'h1, 7'h6D}) begin
            miscompares++;
            $display("FAIL out_ack_hold: got rdy=%b pid=%h addr=%h want 0 1 6d", pktready, pid, addr);
        end
    endtask

    task automatic test_data_pause;
        logic [87:0] v;
        int          i;
        int          ready_cyc;
        v         = mk_data(64'hDEADBEEF_01234567);
        i         = 0;
        ready_cyc = 0;
        for (int c = 1; c <= 112; c++) begin
            if (i < 72) begin
                if (c % 3 == 0) begin
                    drive(1'b1, 1'b1, ~v[i], 1'b0);
                end else begin
                    drive(1'b1, 1'b0, v[i], 1'b0);
                    i++;
                end
            end else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0);
            end
            if (pktready && ready_cyc == 0) ready_cyc = c;
        end
        // 72 accepted bits plus 35 pause cycles: the last bit lands in cycle 107.
        vectors++;
        if (ready_cyc !== 107) begin
            miscompares++;
            $display("FAIL data_latency: got %0d want 107", ready_cyc);
        end
        vectors++;
        if ({pid, addr, endp, data} !== {4'h3, 7'h0, 4'h0, 64'hDEADBEEF_01234567}) begin
            miscompares++;
            $display("FAIL data_fields: got pid=%h addr=%h endp=%h data=%h want 3 0 0 deadbeef01234567",
                     pid, addr, endp, data);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (pktready !== 1'b0) begin
            miscompares++;
            $display("FAIL data_ack: got %b want 0", pktready);
        end
    endtask

    task automatic test_back_to_back;
        int errs0;
        errs0 = n_pid_err + n_trunc + n_overrun;
        send_pkt(mk_hs(4'h2), 8, 1'b0);
        vectors++;
        if ({pktready, pid, addr, endp, data} !== {1'b1, 4'h2, 7'h0, 4'h0, 64'h0}) begin
            miscompares++;
            $display("FAIL ack_pkt: got rdy=%b pid=%h addr=%h want 1 2 0", pktready, pid, addr);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(mk_hs(4'hA), 8, 1'b0);
        vectors++;
        if ({pktready, pid} !== {1'b1, 4'hA}) begin
            miscompares++;
            $display("FAIL nak_pkt: got rdy=%b pid=%h want 1 a", pktready, pid);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if ((n_pid_err + n_trunc + n_overrun) !== errs0 || pktready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_clean: got errs=%0d rdy=%b want errs=%0d rdy=0",
                     n_pid_err + n_trunc + n_overrun, pktready, errs0);
        end
    endtask

    task automatic test_pid_err;
        logic [87:0] v;
        int          e0;
        v        = '0;
        v[7:0]   = 8'b0001_0001;
        v[14:8]  = 7'b1001101;
        e0       = n_pid_err;
        send_pkt(v, 8, 1'b0);
        vectors++;
        if ({pid_err, pktready} !== 2'b10) begin
            miscompares++;
            $display("FAIL pid_err_pulse: got err=%b rdy=%b want 1 0", pid_err, pktready);
        end
        for (int i = 8; i < 15; i++) drive(1'b1, 1'b0, v[i], 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (pktready !== 1'b0 || (n_pid_err - e0) !== 1) begin
            miscompares++;
            $display("FAIL pid_err_discard: got rdy=%b pulses=%0d want 0 1", pktready, n_pid_err - e0);
        end
    endtask

    task automatic test_trunc;
        send_pkt(mk_tok(4'h9, 7'h55, 4'h3), 13, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({trunc_err, pktready} !== 2'b10) begin
            miscompares++;
            $display("FAIL trunc_pulse: got err=%b rdy=%b want 1 0", trunc_err, pktready);
        end
        send_pkt(mk_tok(4'h1, 7'h12, 4'h5), 19, 1'b0);
        vectors++;
        if ({pktready, pid, addr, endp, data} !== {1'b1, 4'h1, 7'h12, 4'h5, 64'h0}) begin
            miscompares++;
            $display("FAIL trunc_next_out: got rdy=%b pid=%h addr=%h endp=%h data=%h want 1 1 12 5 0",
                     pktready, pid, addr, endp, data);
        end
    endtask

    task automatic test_overrun;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(mk_data(64'h01234567_89ABCDEF), 72, 1'b0);
        vectors++;
        if ({overrun, pktready, pid, addr, endp, data} !== {2'b11, 4'h1, 7'h12, 4'h5, 64'h0}) begin
            miscompares++;
            $display("FAIL overrun_hold: got ovr=%b rdy=%b pid=%h addr=%h data=%h want 1 1 1 12 0",
                     overrun, pktready, pid, addr, data);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_width: got %b want 0", overrun);
        end
        send_pkt(mk_hs(4'h2), 8, 1'b1);
        vectors++;
        if ({overrun, pktready, pid} !== {2'b10, 4'h1}) begin
            miscompares++;
            $display("FAIL overrun_with_ack: got ovr=%b rdy=%b pid=%h want 1 0 1", overrun, pktready, pid);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        send_pkt(mk_hs(4'h2), 8, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(mk_data(64'hCAFEF00D_12345678), 20, 1'b0);
        #2;
        rst_L = 1'b0;
        #1;
        vectors++;
        if ({pktready, pid, addr, endp, data, pid_err, trunc_err, overrun} !== 83'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 0",
                     {pktready, pid, addr, endp, data, pid_err, trunc_err, overrun});
        end
        sending = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({pktready, pid_err, trunc_err, overrun} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_no_err: got %b want 0000", {pktready, pid_err, trunc_err, overrun});
        end
        send_pkt(mk_hs(4'hA), 8, 1'b0);
        vectors++;
        if ({pktready, pid, data} !== {1'b1, 4'hA, 64'h0}) begin
            miscompares++;
            $display("FAIL post_reset_pkt: got rdy=%b pid=%h data=%h want 1 a 0", pktready, pid, data);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset;
        test_out;
        test_data_pause;
        test_back_to_back;
        test_pid_err;
        test_trunc;
        test_overrun;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitstream_decoder.md
# bitstream_decoder

Serial receive front end that reassembles packets produced by `bitstream_encoder`. It samples `inb` under the encoder's `sending`/`pause` framing, checks the PID, and collects the fields that PID implies: ADDR+ENDP for OUT/IN, DATA for DATA0, nothing for ACK/NAK. It presents each completed packet on parallel outputs with a ready/ack handshake. It sits between the serial link and the protocol FSM, mirroring the encoder's `pktready`/`gotpkt` handshake on the receive side.

## Interface
- No parameters. Field widths are fixed by the protocol: PID 8, ADDR 7, ENDP 4, DATA 64.
- `clk` input 1: rising-edge clock.
- `rst_L` input 1: reset, asynchronous, active-low.
- `inb` input 1: serial data bit.
- `sending` input 1: frame envelope, high for the whole packet including paused cycles.
- `pause` input 1: when high, the current `inb` is not a bit.
- `pkt_ack` input 1: consumer has taken the held packet.
- `pktready` output 1: a decoded packet is held on the outputs.
- `pid` output 4: decoded PID nibble.
- `addr` output 7: decoded address; 0 unless OUT/IN.
- `endp` output 4: decoded endpoint; 0 unless OUT/IN.
- `data` output 64: decoded payload; 0 unless DATA0.
- `pid_err` output 1: one-cycle pulse for a PID check failure or an unknown PID.
- `trunc_err` output 1: one-cycle pulse when the frame ends before the packet is complete.
- `overrun` output 1: one-cycle pulse when a packet completes while `pktready` is still high.

## Operation
- A bit is accepted in a cycle iff `sending && !pause`.
- Bits within every field arrive LSB first.
- PID field layout: bits 0-3 are `pid`, bits 4-7 are `~pid`.
- Valid PIDs: OUT=0001, IN=1001, DATA0=0011, ACK=0010, NAK=1010.
- States and transitions:
  - IDLE → RX_PID on the first accepted bit.
  - RX_PID: after 8 bits, take one of:
    - check fails (bits 7:4 != ~bits 3:0), or check passes but PID is unknown → pulse `pid_err`, go to DISCARD.
    - ACK/NAK → COMPLETE.
    - OUT/IN → RX_ADDR, then 7 bits → RX_ENDP, then 4 bits → COMPLETE.
    - DATA0 → RX_DATA, then 64 bits → COMPLETE.
  - COMPLETE: packet finished.
    - If `pktready` is low: load the output registers, set `pktready`, go to WAIT_END.
    - If `pktready` is high: discard the packet, pulse `overrun`, go to WAIT_END.
  - WAIT_END: return to IDLE when `sending` is low. Accepted bits here are ignored.
  - DISCARD: return to IDLE when `sending` is low.
- `sending` low in RX_PID, RX_ADDR, RX_ENDP or RX_DATA → pulse `trunc_err`, reset the bit counter and shift register, go to IDLE.
- The bit counter is a single 7-bit counter, cleared on each field transition. It increments only on accepted bits.
- Assembly uses one internal 64-bit shift register; each field's bits are stored at their field positions.
- Output registers update only on a successful COMPLETE. They hold until the next successful COMPLETE.
- `pktready` is cleared on the cycle after `pkt_ack` is sampled high. `pkt_ack` while `pktready` is low is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, counter 0.
- Reset mid-packet abandons the packet with no error pulse.
- Pause cycles add latency and no other effect.
- Latency: if the last bit of the packet is accepted in cycle N:
  - `pktready` and the output fields are valid at N+1.
  - An `overrun` pulse, if any, occurs at N+1.
- `pid_err` pulses the cycle after the 8th PID bit.
- `trunc_err` pulses the cycle after `sending` is first sampled low.
- Simultaneous `pkt_ack` and COMPLETE at the same edge with `pktready` high: treated as overrun. The new packet is dropped, then `pktready` clears.
- The encoder's 2-cycle gap (IDLE then LOAD, `sending` low) is sufficient: WAIT_END → IDLE needs one low cycle. Back-to-back packets must not lose their first bit.
- A `sending` rise while in WAIT_END is not possible with this encoder. If it happens, the bits of that frame are ignored.

## Test plan
- OUT with addr=7'h6D, endp=4'hD, no pause: serial stream 1000 0111 then addr LSB first then endp; `sending` drops after 19 bits → `pktready`=1 one cycle after bit 19, pid=4'h1, addr=7'h6D, endp=4'hD, data=0.
- DATA0 with data=64'hDEADBEEF_01234567 and `pause` high on every 3rd cycle → data matches after 64 accepted bits, and `pktready` is delayed by exactly the number of pause cycles.
- ACK then NAK back-to-back, `pkt_ack` pulsed after each → two packets with pid 4'h2 then 4'hA, no error pulses.
- PID byte 8'b0001_0001 (check fails) followed by 7 more bits → `pid_err` pulse after bit 8, no `pktready`, returns to IDLE when `sending` drops.
- IN frame with `sending` dropped after 5 ADDR bits → `trunc_err` pulse, no `pktready`; a following OUT packet decodes correctly.
- Complete a packet, withhold `pkt_ack`, complete a second packet → `overrun` pulse, outputs still hold the first packet; `rst_L` asserted mid-DATA0 → all outputs 0 immediately.
